rom_boot_ctrl: RTL

//  Boot sequencer for the instruction ROM of riscv_cpu_soc. Takes a program from a

---
 rtl/rom_boot_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rom_boot_ctrl.sv
// rom_boot_ctrl: loads a host word stream into the instruction ROM, holding the CPU in reset until done.
// Optional ROM_NOP_FILL_EN: pad the ROM above load_len with NOPs before releasing the core.
module rom_boot_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int DEPTH        = 4096,
    parameter int RELEASE_DLY  = 4,
    parameter int HOLD_ON_BOOT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2(RELEASE_DLY + 2);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RELEASE
`ifdef ROM_NOP_FILL_EN
        , FILL
`endif
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   addr, addr_nx, len, len_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              we_nx, crst_nx, done_nx, err_nx, boot;
    logic [ADDR_W-1:0] waddr_nx;
    logic [31:0]       wdata_nx;

    assign s_ready = state == LOAD;
    assign busy    = state != IDLE;

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        len_nx   = len;
        cnt_nx   = cnt;
        we_nx    = 1'b0;
        waddr_nx = rom_waddr;
        wdata_nx = rom_wdata;
        crst_nx  = cpu_rst_n;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        if (state != IDLE && load_abort) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (boot && HOLD_ON_BOOT == 0) crst_nx = 1'b1;
                    if (load_start) begin
                        if (load_len == '0 || load_len > DEPTH_L) err_nx = 1'b1;
                        else begin
                            crst_nx  = 1'b0;
                            addr_nx  = '0;
                            len_nx   = load_len;
                            state_nx = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        we_nx    = 1'b1;
                        waddr_nx = addr[ADDR_W-1:0];
                        wdata_nx = s_data;
                        addr_nx  = addr + 1'b1;
                        cnt_nx   = '0;
`ifdef ROM_NOP_FILL_EN
                        if (addr + 1'b1 == len) state_nx = len != DEPTH_L ? FILL : RELEASE;
`else
                        if (addr + 1'b1 == len) state_nx = RELEASE;
`endif
                    end
                end
`ifdef ROM_NOP_FILL_EN
                FILL: begin
                    we_nx    = 1'b1;
                    waddr_nx = addr[ADDR_W-1:0];
                    wdata_nx = 32'h0000_0013;
                    addr_nx  = addr + 1'b1;
                    cnt_nx   = '0;
                    if (addr == DEPTH_L - 1'b1) state_nx = RELEASE;
                end
`endif
                RELEASE: begin
                    // the delay is counted from the cycle the final write is visible
                    if (cnt == CW'(RELEASE_DLY)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                        crst_nx  = 1'b1;
                    end else cnt_nx = cnt + 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            len       <= '0;
            cnt       <= '0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            boot      <= 1'b1;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            len       <= len_nx;
            cnt       <= cnt_nx;
            rom_we    <= we_nx;
            rom_waddr <= waddr_nx;
            rom_wdata <= wdata_nx;
            cpu_rst_n <= crst_nx;
            done      <= done_nx;
            err       <= err_nx;
            boot      <= 1'b0;
        end
    end
endmodule
